// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter.
// Holds the FSM state encoding, 8N1 frame constants and default baud divider.
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS       = 8;
    localparam int STOP_BITS       = 1;
    localparam int DEFAULT_CLK_DIV = 434;

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with occupancy count.
// Ports: clk_in, rst, push/wr_data in, pop in, rd_data (head), full, empty, level.
module sync_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               wr_data,
    input  logic                     pop,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A push while full is dropped even when a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full    = (level == (AW + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst && do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a byte FIFO; frames go out back to back.
// Ports: clk_in, rst, wr_en/wr_data (queue a byte), full, level, busy, tx_out.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int DEPTH   = 8
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     tx_out
);

    localparam logic [15:0] RELOAD   = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t   state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        avail_q;
    logic        empty;
    logic        pop;
    logic        tick;
    logic [7:0]  head;

    sync_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_in  (clk_in),
        .rst     (rst),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign tick = (baud_cnt == '0);

    // From IDLE a frame starts one cycle after the FIFO turns non-empty
    // (avail_q), fixing the write-to-start-bit latency at two edges.
    // From STOP the next head byte is taken with no gap.
    assign pop = !empty &&
                 (((state == IDLE) && avail_q) ||
                  ((state == STOP) && tick));

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= IDLE;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            avail_q  <= 1'b0;
        end else begin
            avail_q <= !empty;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        shreg    <= head;
                        baud_cnt <= RELOAD;
                        tx_out   <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        baud_cnt <= RELOAD;
                        tx_out   <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        baud_cnt <= RELOAD;
                        if (bit_idx == LAST_BIT) begin
                            tx_out  <= 1'b1;
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            tx_out  <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (pop) begin
                            shreg    <= head;
                            baud_cnt <= RELOAD;
                            tx_out   <= 1'b0;
                            state    <= START;
                        end else begin
                            baud_cnt <= '0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLK_DIV=4, DEPTH=4.
// A line monitor decodes frames; expected bytes are hand-listed per test.
module tb_uart_tx_fifo;

    logic       clk_in;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic [2:0] level;
    logic       busy;
    logic       tx_out;

    int n_chk = 0;
    int n_err = 0;
    int rst_cnt = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    uart_tx_fifo #(
        .CLK_DIV(4),
        .DEPTH  (4)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .level   (level),
        .busy    (busy),
        .tx_out  (tx_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (rst) rst_cnt <= rst_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size())
                chk({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
            else
                chk({tag, "_missing"}, 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (4) @(negedge clk_in);
        while ((busy || level != 0) && n < 2000) begin
            @(negedge clk_in);
            n++;
        end
        chk("idle_wait", 32'(n < 2000), 1);
        repeat (2) @(negedge clk_in);
    endtask

    // Called on the negedge right after the start bit begins.
    task automatic expect_frame(input logic [7:0] b);
        logic [9:0] frm;
        frm = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (k != 0 || c != 0) @(negedge clk_in);
                chk("line", 32'(tx_out), 32'(frm[k]));
                chk("busy_frame", 32'(busy), 1);
            end
        end
    endtask

    // Line monitor: samples each bit mid-window, drops frames hit by reset.
    initial begin
        logic [7:0] d;
        logic       st;
        logic       sp;
        int         r0;
        forever begin
            @(negedge clk_in);
            if (!rst && tx_out === 1'b0) begin
                r0 = rst_cnt;
                @(negedge clk_in);
                st = tx_out;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk_in);
                    d[i] = tx_out;
                end
                repeat (4) @(negedge clk_in);
                sp = tx_out;
                repeat (2) @(negedge clk_in);
                if (rst_cnt == r0) begin
                    chk("rx_start", 32'(st), 0);
                    chk("rx_stop", 32'(sp), 1);
                    rx_q.push_back(d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int sent;
        int guard;
        logic saw_full;

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        @(negedge clk_in);
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        @(negedge clk_in);
        wr_en   = 1'b0;
        @(negedge clk_in);
        chk("rst_tx", 32'(tx_out), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_level", 32'(level), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_wr_ignored", 32'(level), 0);
        chk("rst_no_frame", 32'(busy), 0);

        // Single byte 0xA5
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        @(negedge clk_in);
        wr_en = 1'b0;
        chk("single_level1", 32'(level), 1);
        chk("single_tx_e0", 32'(tx_out), 1);
        @(negedge clk_in);
        chk("single_tx_e1", 32'(tx_out), 1);
        @(negedge clk_in);
        chk("single_level0", 32'(level), 0);
        expect_frame(8'hA5);
        @(negedge clk_in);
        chk("single_busy_end", 32'(busy), 0);
        chk("single_tx_end", 32'(tx_out), 1);
        chk("single_level_end", 32'(level), 0);
        wait_idle();
        exp_q.push_back(8'hA5);
        check_rx("single");

        // Back-to-back; third write lands on the IDLE pop edge
        wr_en   = 1'b1;
        wr_data = 8'h00;
        @(negedge clk_in);
        wr_data = 8'hFF;
        @(negedge clk_in);
        wr_data = 8'h55;
        @(negedge clk_in);
        wr_en = 1'b0;
        chk("b2b_level_pushpop", 32'(level), 2);
        chk("b2b_tx_start", 32'(tx_out), 0);
        n = 0;
        while (busy && n < 300) begin
            n++;
            @(negedge clk_in);
        end
        chk("b2b_busy_cycles", n, 120);
        wait_idle();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        check_rx("b2b");

        // Overflow: six writes, sixth dropped; then write on full STOP pop
        wr_en   = 1'b1;
        wr_data = 8'h10;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk_in);
            wr_data = 8'(8'h10 + i);
        end
        @(negedge clk_in);
        wr_en = 1'b0;
        chk("ovf_level", 32'(level), 4);
        chk("ovf_full", 32'(full), 1);
        repeat (36) @(negedge clk_in);
        chk("ovf_full_pre_pop", 32'(full), 1);
        wr_en   = 1'b1;
        wr_data = 8'h99;
        @(negedge clk_in);
        wr_en = 1'b0;
        chk("ovf_pop_level", 32'(level), 3);
        chk("ovf_pop_full", 32'(full), 0);
        chk("ovf_next_start", 32'(tx_out), 0);
        wait_idle();
        for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h10 + i));
        check_rx("ovf");

        // Wrap-around stream with flow control on full
        sent     = 0;
        guard    = 0;
        saw_full = 1'b0;
        while (sent < 20 && guard < 3000) begin
            @(negedge clk_in);
            guard++;
            if (full) saw_full = 1'b1;
            if (!full) begin
                wr_en   = 1'b1;
                wr_data = 8'(sent);
                sent++;
            end else begin
                wr_en = 1'b0;
            end
        end
        @(negedge clk_in);
        wr_en = 1'b0;
        chk("wrap_sent", sent, 20);
        chk("wrap_saw_full", 32'(saw_full), 1);
        wait_idle();
        for (int i = 0; i < 20; i++) exp_q.push_back(8'(i));
        check_rx("wrap");

        // Reset during data bit 3 of 0x3C with two bytes queued
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        @(negedge clk_in);
        wr_data = 8'h01;
        @(negedge clk_in);
        wr_data = 8'h02;
        @(negedge clk_in);
        wr_en = 1'b0;
        repeat (16) @(negedge clk_in);
        chk("mrst_pre_level", 32'(level), 2);
        chk("mrst_pre_busy", 32'(busy), 1);
        chk("mrst_pre_bit3", 32'(tx_out), 1);
        rst = 1'b1;
        @(negedge clk_in);
        chk("mrst_tx", 32'(tx_out), 1);
        chk("mrst_level", 32'(level), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_full", 32'(full), 0);
        rst = 1'b0;
        n = 0;
        repeat (150) begin
            @(negedge clk_in);
            if (busy) n++;
        end
        chk("mrst_no_frames", n, 0);
        check_rx("mrst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 434, giving clock cycles per bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving FIFO depth in bytes; legal values are powers of two from 2 to 64.
REQ-003 Port clk_in, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1 bit: reset; synchronous, active-high.
REQ-005 Port wr_en, input, 1 bit: byte write strobe, sampled each clock.
REQ-006 Port wr_data, input, 8 bits: byte to queue, sampled when wr_en=1.
REQ-007 Port full, output, 1 bit: FIFO holds DEPTH bytes.
REQ-008 Port level, output, clog2(DEPTH)+1 bits: number of bytes queued, excluding the byte in flight.
REQ-009 Port busy, output, 1 bit: a frame is being shifted out.
REQ-010 Port tx_out, output, 1 bit: serial line, idle high.

Function
REQ-011 Frame format SHALL be 8N1: one start bit (0), eight data bits LSB first, one stop bit (1).
REQ-012 Each bit SHALL last exactly CLK_DIV clock cycles, so one frame lasts 10*CLK_DIV cycles.
REQ-013 A write with wr_en=1 and full=0 SHALL enqueue wr_data at that edge, and level SHALL increment on the same edge.
REQ-014 A write with wr_en=1 and full=1 SHALL be discarded with no state change, even if a pop occurs in the same cycle.
REQ-015 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-016 IDLE -> START: when the FIFO is non-empty, pop the head byte into the shift register, load the baud counter, and drive tx_out=0.
REQ-017 START -> DATA: after CLK_DIV cycles.
REQ-018 DATA: shift out one bit per CLK_DIV cycles; the 3-bit bit index runs 0..7, then the FSM goes to STOP.
REQ-019 STOP -> START or IDLE: after CLK_DIV cycles of tx_out=1, go directly to START if the FIFO is non-empty (no idle gap between frames); otherwise go to IDLE.
REQ-020 Latency: a byte written into an empty FIFO while in IDLE SHALL drive tx_out low starting at the second rising edge after the write edge.
REQ-021 The baud counter SHALL run only outside IDLE and SHALL be reloaded at every bit boundary; it SHALL NOT free-run.
REQ-022 Simultaneous write and pop with full=0 SHALL leave level unchanged and SHALL preserve FIFO order.
REQ-023 FIFO read and write pointers SHALL be clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-024 The full flag SHALL equal (level==DEPTH).
REQ-025 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-026 tx_out SHALL be driven from a register with no combinational path from any input.

Reset
REQ-027 While rst=1 at a clock edge, the following SHALL be forced: tx_out=1, busy=0, full=0, level=0, FSM=IDLE, pointers=0, baud counter=0, bit index=0.
REQ-028 Reset mid-frame SHALL abort the frame immediately: tx_out returns high at that edge, and all queued bytes are dropped.
REQ-029 Writes during the rst=1 cycle SHALL be ignored.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (2-bit), the frame constants (data bits=8, stop bits=1) and the default CLK_DIV.
REQ-031 The FIFO SHALL be a separate sub-module, sync_fifo (parameter DEPTH, 8-bit data, push/pop/full/empty/level); the FSM and baud counter stay in uart_tx_fifo.

Verification (benches use CLK_DIV=4, DEPTH=4)
REQ-032 Single byte: write 0xA5 to an idle block -> tx_out low 2 edges later; line pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy=1 for 40 cycles; level returns to 0.
REQ-033 Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles -> three frames, 120 cycles, no idle gap between stop and next start; data matches write order.
REQ-034 Overflow: write 6 bytes on consecutive cycles while idle -> first byte popped; next 4 queued; full=1; sixth write discarded; exactly 5 frames emitted.
REQ-035 Wrap-around: stream 20 bytes 0x00..0x13 with writes held off while full=1 -> all 20 received in order; pointers wrap without loss.
REQ-036 Reset mid-frame: assert rst during bit 3 of 0x3C with 2 bytes queued -> tx_out=1, level=0 and busy=0 on that edge; no further frames after release.
REQ-037 Simultaneous push/pop: with level=4, full=1, write as STOP ends -> write discarded, level=3; with level=2, write at pop edge -> level stays 2.
